// File: rtl/wisc_pkg.sv
// Shared types for the WISC memory stage: FSM state encoding,
// default datapath widths and the EX/MEM and MEM/WB register bundles.
package wisc_pkg;

    localparam int WISC_DATA_W = 16;
    localparam int WISC_REG_W  = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic [WISC_DATA_W-1:0] alu_out;
        logic [WISC_DATA_W-1:0] rt_data;
        logic [WISC_REG_W-1:0]  dest;
        logic                   is_mem;
        logic                   mem_write;
        logic                   reg_write;
        logic                   mem_to_reg;
    } exmem_t;

    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic [WISC_REG_W-1:0]  dest;
        logic [WISC_DATA_W-1:0] data;
    } memwb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access FSM: tracks an outstanding request, decides when the
// EX/MEM entry retires and back-pressures the execute stage.
// Ports: clk, rst_n (sync, active-low); exmem_valid, is_mem, mem_ack in;
//        retire, ex_ready, timeout (forced retire), mem_err (sticky) out.
// Optional watchdog enabled by MEM_STAGE_TIMEOUT_EN.
module mem_access_fsm
    import wisc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic exmem_valid,
    input  logic is_mem,
    input  logic mem_ack,
    output logic retire,
    output logic ex_ready,
    output logic timeout,
    output logic mem_err
);

    mem_state_t state;
    logic       req;

    assign req = exmem_valid & is_mem;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // cnt = request cycles already spent without an ack (0 in IDLE)
    logic [CNT_W-1:0] cnt;

    assign timeout = req & ~mem_ack
                   & (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            if (req && !mem_ack && !timeout)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (timeout)
                mem_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign retire   = exmem_valid & (~is_mem | mem_ack | timeout);
    assign ex_ready = ~exmem_valid | retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:
                    if (req && !mem_ack && !timeout)
                        state <= WAIT;
                WAIT:
                    if (!req || mem_ack || timeout)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// WISC memory stage: EX/MEM and MEM/WB registers, data-memory handshake,
// execute-stage stall and both forwarding sources (ex2ex, mem2ex=wb_data).
// Ports: clk, rst_n (sync, active-low); ex_* capture bundle + ex_ready;
//        mem_req/we/addr/wdata/rdata/ack memory port; ex2ex_data,
//        exmem_dest, exmem_reg_write forwarding; wb_* MEM/WB; mem_err.
// Optional watchdog enabled by MEM_STAGE_TIMEOUT_EN.
module mem_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W      = WISC_DATA_W,
    parameter int REG_W       = WISC_REG_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_rt_data,
    input  logic [REG_W-1:0]  ex_dest_reg,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ex2ex_data,
    output logic [REG_W-1:0]  exmem_dest,
    output logic              exmem_reg_write,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    logic   exmem_valid;
    exmem_t exmem;
    memwb_t memwb;
    logic   retire;
    logic   timeout;

    mem_access_fsm #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .exmem_valid(exmem_valid),
        .is_mem     (exmem.is_mem),
        .mem_ack    (mem_ack),
        .retire     (retire),
        .ex_ready   (ex_ready),
        .timeout    (timeout),
        .mem_err    (mem_err)
    );

    // Request fields come straight from EX/MEM, so they stay stable
    // for as long as the entry is held.
    assign mem_req   = exmem_valid & exmem.is_mem;
    assign mem_we    = exmem.mem_write;
    assign mem_addr  = exmem.alu_out;
    assign mem_wdata = exmem.rt_data;

    // Stale EX/MEM content must not be seen as a forwarding source.
    assign ex2ex_data      = exmem.alu_out;
    assign exmem_dest      = exmem.dest;
    assign exmem_reg_write = exmem.reg_write & exmem_valid;

    assign wb_valid     = memwb.valid;
    assign wb_reg_write = memwb.reg_write;
    assign wb_dest      = memwb.dest;
    assign wb_data      = memwb.data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exmem_valid <= 1'b0;
            exmem       <= '0;
            memwb       <= '0;
        end else begin
            if (ex_valid && ex_ready) begin
                exmem_valid      <= 1'b1;
                exmem.alu_out    <= ex_alu_out;
                exmem.rt_data    <= ex_rt_data;
                exmem.dest       <= ex_dest_reg;
                exmem.is_mem     <= ex_mem_read | ex_mem_write;
                exmem.mem_write  <= ex_mem_write;
                exmem.reg_write  <= ex_reg_write;
                exmem.mem_to_reg <= ex_mem_to_reg;
            end else if (retire) begin
                exmem_valid <= 1'b0;
            end

            memwb.valid <= retire;
            if (retire) begin
                memwb.dest      <= exmem.dest;
                // A watchdog-forced retire must never write the register file.
                memwb.reg_write <= exmem.reg_write & ~timeout;
                if (timeout)
                    memwb.data <= '0;
                else if (exmem.mem_to_reg)
                    memwb.data <= mem_rdata;
                else
                    memwb.data <= exmem.alu_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard testbench for mem_stage: directed stimulus pushes expected
// MEM/WB results; a monitor pops and compares on every wb_valid.
module tb_mem_stage;

    typedef struct {
        logic [3:0]  dest;
        logic        rw;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_rt_data;
    logic [3:0]  ex_dest_reg;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] ex2ex_data;
    logic [3:0]  exmem_dest;
    logic        exmem_reg_write;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        mem_err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    // memory model: ack in the (wait_k+1)th request cycle
    int  wait_k   = 0;
    int  req_cnt  = 0;
    logic no_ack  = 1'b0;
    logic ack_high = 1'b0;

    assign mem_ack = ack_high
                   | (mem_req && !no_ack && (req_cnt == wait_k));

    always @(posedge clk) begin
        if (mem_req && !mem_ack)
            req_cnt <= req_cnt + 1;
        else
            req_cnt <= 0;
    end

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W(16),
        .REG_W(4),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_out     (ex_alu_out),
        .ex_rt_data     (ex_rt_data),
        .ex_dest_reg    (ex_dest_reg),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .ex2ex_data     (ex2ex_data),
        .exmem_dest     (exmem_dest),
        .exmem_reg_write(exmem_reg_write),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_dest        (wb_dest),
        .wb_data        (wb_data),
        .mem_err        (mem_err)
    );

    // monitor
    always @(negedge clk) begin
        if (wb_valid) begin
            exp_t e;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got dest=%0d rw=%0b data=%h, want none",
                         wb_dest, wb_reg_write, wb_data);
            end else begin
                e = sb_q.pop_front();
                if (wb_dest !== e.dest || wb_reg_write !== e.rw
                    || wb_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_wb: got dest=%0d rw=%0b data=%h, want dest=%0d rw=%0b data=%h",
                             wb_dest, wb_reg_write, wb_data,
                             e.dest, e.rw, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [15:0] alu, input logic [15:0] rt,
                          input logic [3:0] dest, input logic rd,
                          input logic wr, input logic rw, input logic m2r);
        ex_valid      = 1'b1;
        ex_alu_out    = alu;
        ex_rt_data    = rt;
        ex_dest_reg   = dest;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
    endtask

    task automatic push(input logic [3:0] d, input logic rw,
                        input logic [15:0] data);
        exp_t e;
        e.dest = d;
        e.rw   = rw;
        e.data = data;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int stalls;
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_alu_out    = '0;
        ex_rt_data    = '0;
        ex_dest_reg   = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
        mem_rdata     = '0;
        cyc();
        cyc();
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        rst_n = 1'b1;
        cyc();

        // ALU op
        set_op(16'h1234, 16'h0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'd5, 1'b1, 16'h1234);
        chk("alu_ready", 32'(ex_ready), 32'd1);
        cyc();
        ex_valid = 1'b0;
        chk("alu_ready_cap", 32'(ex_ready), 32'd1);
        chk("alu_no_req", 32'(mem_req), 32'd0);
        chk("alu_fwd", 32'(ex2ex_data), 32'h1234);
        cyc();
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        cyc();
        chk("alu_wb_drop", 32'(wb_valid), 32'd0);

        // zero-wait load
        wait_k    = 0;
        mem_rdata = 16'hBEEF;
        set_op(16'h0040, 16'h0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        push(4'd3, 1'b1, 16'hBEEF);
        cyc();
        ex_valid = 1'b0;
        chk("ld0_req", 32'(mem_req), 32'd1);
        chk("ld0_we", 32'(mem_we), 32'd0);
        chk("ld0_addr", 32'(mem_addr), 32'h0040);
        chk("ld0_ready", 32'(ex_ready), 32'd1);
        cyc();
        chk("ld0_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld0_req_drop", 32'(mem_req), 32'd0);

        // 3-wait store
        wait_k = 3;
        set_op(16'h0010, 16'hA5A5, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        push(4'd2, 1'b0, 16'h0010);
        cyc();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st_stall", 32'(ex_ready), 32'd0);
            chk("st_req", 32'(mem_req), 32'd1);
            chk("st_we", 32'(mem_we), 32'd1);
            chk("st_addr", 32'(mem_addr), 32'h0010);
            chk("st_wdata", 32'(mem_wdata), 32'hA5A5);
            chk("st_wb_idle", 32'(wb_valid), 32'd0);
            cyc();
        end
        chk("st_ack", 32'(mem_ack), 32'd1);
        chk("st_ready", 32'(ex_ready), 32'd1);
        cyc();
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        chk("st_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("st_req_drop", 32'(mem_req), 32'd0);

        // back-to-back: 2-wait load then ALU op
        wait_k    = 2;
        mem_rdata = 16'h1111;
        set_op(16'h0080, 16'h0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        push(4'd4, 1'b1, 16'h1111);
        cyc();
        set_op(16'h0007, 16'h0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'd6, 1'b1, 16'h0007);
        stalls = 0;
        for (int i = 0; i < 20 && !ex_ready; i++) begin
            stalls++;
            cyc();
        end
        chk("b2b_stalls", 32'(stalls), 32'd2);
        chk("b2b_ack", 32'(mem_ack), 32'd1);
        cyc();
        ex_valid = 1'b0;
        chk("b2b_wb1", 32'(wb_valid), 32'd1);
        cyc();
        chk("b2b_wb2", 32'(wb_valid), 32'd1);
        cyc();
        chk("b2b_wb_drop", 32'(wb_valid), 32'd0);

        // reset during WAIT
        no_ack = 1'b1;
        set_op(16'h0022, 16'h0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        ex_valid = 1'b0;
        cyc();
        chk("rw_req", 32'(mem_req), 32'd1);
        chk("rw_stall", 32'(ex_ready), 32'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rw_req_drop", 32'(mem_req), 32'd0);
        chk("rw_wb_valid", 32'(wb_valid), 32'd0);
        chk("rw_ready", 32'(ex_ready), 32'd1);
        no_ack   = 1'b0;
        ack_high = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rw_late_ack", 32'(wb_valid), 32'd0);
        end
        ack_high = 1'b0;
        wait_k   = 0;

`ifdef MEM_STAGE_TIMEOUT_EN
        // watchdog: ack never comes, limit 4 request cycles
        no_ack    = 1'b1;
        mem_rdata = 16'hFFFF;
        set_op(16'h0050, 16'h0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        push(4'd7, 1'b0, 16'h0000);
        cyc();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("to_stall", 32'(ex_ready), 32'd0);
            cyc();
        end
        chk("to_err_pre", 32'(mem_err), 32'd0);
        chk("to_ready", 32'(ex_ready), 32'd1);
        cyc();
        chk("to_wb_valid", 32'(wb_valid), 32'd1);
        chk("to_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        no_ack = 1'b0;
`endif

        // pipeline still flows
        set_op(16'h00AB, 16'h0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'd1, 1'b1, 16'h00AB);
        cyc();
        ex_valid = 1'b0;
        cyc();
        chk("end_wb_valid", 32'(wb_valid), 32'd1);
`ifdef MEM_STAGE_TIMEOUT_EN
        chk("end_mem_err", 32'(mem_err), 32'd1);
`else
        chk("end_mem_err", 32'(mem_err), 32'd0);
`endif
        cyc();
        cyc();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the WISC 5-stage pipeline: the consumer of the execute stage's result bus. Holds the EX/MEM pipeline register and drives a variable-latency data-memory request/acknowledge handshake. Stalls the execute stage while a load/store is outstanding and retires into the MEM/WB register. Sources both forwarding operands (ex2ex and mem2ex) back to the execute stage.

## Interface
Parameters:
- DATA_W, 16, datapath width
- REG_W, 4, register-index width
- TIMEOUT_CYC, 15, watchdog limit in cycles (used only with MEM_STAGE_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  mem_stage accepts it this cycle
- ex_alu_out  in  DATA_W  ALU result / memory address
- ex_rt_data  in  DATA_W  store data
- ex_dest_reg  in  REG_W  destination register
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  control bits
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  access complete this cycle
- ex2ex_data  out  DATA_W  EX/MEM ALU result, for forwarding
- exmem_dest, exmem_reg_write  out  REG_W, 1  for the forwarding unit
- wb_valid, wb_reg_write  out  1 each  MEM/WB valid and write enable
- wb_dest  out  REG_W  MEM/WB destination
- wb_data  out  DATA_W  MEM/WB writeback value (= mem2ex forwarding value)
- mem_err  out  1  sticky timeout flag

## Operation
- EX/MEM register loads on `ex_valid && ex_ready`. Otherwise exmem_valid clears when its content retires, or holds while stalled.
- is_mem = ex_mem_read | ex_mem_write (registered).
- mem_req = exmem_valid & is_mem. mem_we = exmem mem_write. mem_addr = exmem ALU result. mem_wdata = exmem rt data. All are held stable until mem_ack.
- FSM (mem_access_fsm):
  - IDLE: no request outstanding. On the first request cycle with mem_ack=1 (zero wait), stay in IDLE. With mem_ack=0, go to WAIT.
  - WAIT: request held. On mem_ack=1, go to IDLE.
- retire = exmem_valid & (!is_mem | mem_ack).
- ex_ready = !exmem_valid | retire. This is combinational from mem_ack.
- On retire, MEM/WB loads:
  - wb_valid=1, wb_dest = exmem_dest, wb_reg_write = exmem reg_write.
  - wb_data = mem_rdata if mem_to_reg, else the ALU result.
- With no retire, wb_valid=0 and the other MEM/WB fields hold.
- Retire and a new capture in the same cycle: both happen, so back-to-back flow has no bubble.
- Stores retire with wb_reg_write = exmem reg_write (normally 0).

## Timing
- Reset: all registers clear. exmem_valid=0, wb_valid=0, wb_reg_write=0, wb_data=0, wb_dest=0, mem_req=0, mem_err=0, FSM in IDLE, ex_ready=1.
- Non-memory op: captured at edge N, appears in MEM/WB at edge N+1.
- Load/store with k wait cycles (mem_ack in the (k+1)th request cycle): MEM/WB loads at edge N+1+k. ex_ready is low for k cycles.
- mem_ack while mem_req=0 is ignored.
- Reset during WAIT: mem_req drops in the cycle after the reset edge and the access is abandoned. Memory must tolerate an abandoned request.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYC+1)-bit counter runs in WAIT.
  - When TIMEOUT_CYC request cycles pass without mem_ack, the FSM forces a retire with wb_data=0 and wb_reg_write=0, drops mem_req, and sets mem_err.
  - mem_err stays set until reset.
- Undefined: WAIT lasts indefinitely, and mem_err is tied to 0 (the port is still present).

## Structure
- wisc_pkg holds:
  - typedef enum mem_state_t {IDLE, WAIT}
  - DATA_W/REG_W defaults
  - struct exmem_t (ALU result, rt data, destination, control bits)
  - struct memwb_t
- One sub-module, mem_access_fsm: FSM, retire/ex_ready logic, optional watchdog. The pipeline registers live in mem_stage.

## Test plan
- ALU op: alu_out=16'h1234, dest=5, reg_write=1 → next edge wb_valid=1, wb_data=16'h1234, wb_dest=5. ex_ready stays 1.
- Zero-wait load: addr 16'h0040, mem_ack tied high, mem_rdata=16'hBEEF, mem_to_reg=1 → mem_req high one cycle, wb_data=16'hBEEF one cycle later, no stall.
- 3-wait store: addr 16'h0010, wdata 16'hA5A5, ack on the 4th request cycle → ex_ready low 3 cycles, then mem_req/mem_we/addr/wdata held stable, then retire with wb_reg_write=0.
- Back-to-back: a load with 2 waits followed by ALU op 16'h0007 → ALU op captured in the ack cycle, so wb_data=16'h0007 appears on consecutive cycles with no bubble.
- rst_n low during WAIT → next cycle mem_req=0, wb_valid=0, ex_ready=1. A later ack is ignored.
- MEM_STAGE_TIMEOUT_EN with TIMEOUT_CYC=4, ack never asserted → after 4 request cycles mem_err=1, wb_valid=1, wb_reg_write=0, and the pipeline resumes.
